sar_adc_sequencer: RTL and testbench
====================================

# sar_adc_sequencer

Successive-approximation sequencer for the 8-bit SAR/timer datapath. It owns the trial code `SAROut` and the phase code `StateP`. It performs a full binary-search conversion on `Start`, then optionally stays in tracking mode. In tracking mode it steps the code by ±1 on each timer `Ready` tick and issues `Inc`/`Dcr` to the timer block. It sits between the comparator/DAC front end and the SAR timer, and it is the only writer of `SAROut` and `StateP`.

## Interface
- `SAMPLE_CYCLES`, default 2: cycles `SampleEn` stays high before conversion. Legal range 1..15.
- `SETTLE`, default 1: extra DAC settling cycles per bit. Each bit slot is `SETTLE+1` cycles. Legal range 0..7.

- `ClockT` in 1: single clock, rising edge.
- `ResetN` in 1: asynchronous, active-low reset.
- `Start` in 1: level-sampled conversion request.
- `TrackEn` in 1: enter or stay in tracking mode after conversion.
- `Comp` in 1: comparator result; 1 means input ≥ DAC(`SAROut`).
- `Ready` in 1: tracking tick from the timer.
- `SAROut` out 8: trial/tracked code driven to the DAC.
- `StateP` out 2: phase code. 00 = idle/sample, 11 = convert, 01 = last track step was up, 10 = last track step was down.
- `SampleEn` out 1: sample/hold switch closed.
- `Inc` out 1: one-cycle pulse, code incremented.
- `Dcr` out 1: one-cycle pulse, code decremented.
- `Busy` out 1: high in SAMPLE and CONVERT.
- `Done` out 1: one-cycle pulse, `Result` updated by conversion.
- `Result` out 8: last completed conversion or tracked code.

## Operation
- States: IDLE, SAMPLE, CONVERT, TRACK. All outputs are registered.
- Reset values: state IDLE, `SAROut`=0x00, `Result`=0x00, `StateP`=00, `SampleEn`=0, `Inc`=0, `Dcr`=0, `Busy`=0, `Done`=0. Internal bit index and cycle counters are 0.
- **IDLE:**
  - `StateP`=00; `SAROut` holds.
  - `Start`=1 → SAMPLE.
  - `TrackEn` alone does nothing.
- **SAMPLE:**
  - `SampleEn`=1 and `StateP`=00 for exactly `SAMPLE_CYCLES` cycles.
  - Then go to CONVERT with `SAROut`=0x80 and bit index 7.
- **CONVERT:**
  - `StateP`=11; bit index i runs from 7 down to 0.
  - `Comp` is sampled in the last cycle of each slot. If it is 0, clear bit i.
  - If i>0, also set bit i-1 in the same update.
  - After the bit-0 decision: `Result` ← final code and `Done`=1 for one cycle.
  - Next state is TRACK if `TrackEn`=1, else IDLE.
- **TRACK:**
  - On a cycle with `Ready`=1:
    - `Comp`=1 and `SAROut`≠0xFF → `SAROut`+1, `Inc` pulse, `StateP`=01.
    - `Comp`=0 and `SAROut`≠0x00 → `SAROut`-1, `Dcr` pulse, `StateP`=10.
    - Saturated (0xFF with `Comp`=1, or 0x00 with `Comp`=0) → no change, no pulse, `StateP` holds.
  - `Result` follows `SAROut` on every step. `Done` is not pulsed in tracking.
  - `TrackEn`=0 → IDLE (`StateP`=00), with priority over `Ready`.
  - `Start`=1 → SAMPLE, with priority over `TrackEn` and `Ready`.
- Simultaneous events:
  - `Start` during SAMPLE or CONVERT is ignored; there is no queueing.
  - `Inc` and `Dcr` are never high together.
- Arithmetic is unsigned 8-bit. Tracking saturates and never wraps.
- `ResetN` low at any time, including mid-conversion, forces reset values immediately. After release the block is IDLE; it needs a fresh `Start` and does not resume.
- Tracking a static input dithers ±1 LSB around the threshold code. This is intended.

## Timing
- `Start` is captured at edge k. SAMPLE occupies the cycles after edges k+1 … k+`SAMPLE_CYCLES`.
- First trial code 0x80 appears after edge k+`SAMPLE_CYCLES`+1.
- Each trial code is stable for `SETTLE`+1 cycles before its `Comp` sample.
- `Done` and the final `Result` are visible after edge k+1+`SAMPLE_CYCLES`+8·(`SETTLE`+1). With defaults that is k+19.
- Tracking: a `Ready` sampled at edge m produces the new `SAROut`, `Inc`/`Dcr` and `StateP` after edge m+1.
- `Inc`/`Dcr` last exactly one cycle.
- Back-to-back `Ready` pulses give one step per cycle.

## Test plan
- **Conversion, defaults:** ideal comparator with input code 0xA5, `Start` pulse.
  - Trial codes 80, C0, A0, B0, A8, A4, A6, A5.
  - `Result`=0xA5; `Done` at k+19.
  - `Busy` high for 18 cycles; `StateP`=11 during conversion.
- **Tracking up:** after conversion to 0x10 with `TrackEn`=1, input is raised to 0x13 and `Ready` pulses every 4 cycles.
  - Three `Inc` pulses; `SAROut` steps 11, 12, 13.
  - Then ±1 dither: `Inc`/`Dcr` alternate, `StateP` alternates 01/10.
- **Saturation:** code 0xFF with `Comp`=1 and `Ready` pulses → no `Inc`, `SAROut` stays 0xFF. Code 0x00 with `Comp`=0 → no `Dcr`.
- **Collisions:**
  - `Start` asserted during CONVERT → ignored, `Result` unchanged until the original `Done`.
  - `Start` in TRACK together with `Ready` → SAMPLE entered, no `Inc`/`Dcr`.
- **Reset mid-operation:** `ResetN` low at bit 4 of a conversion.
  - All outputs go to reset values asynchronously, before the next edge.
  - After release: IDLE, no `Done` until a new `Start`.
- **Parameter sweep:** `SAMPLE_CYCLES`=1, `SETTLE`=0 → `Done` at k+10 with a correct result.

Source files
------------

// File: rtl/sar_adc_sequencer_if.sv
// Bundle of the sequencer's request and status signals.
// master: the front end / timer side that drives Start, TrackEn, Comp and Ready.
// slave:  the sequencer itself, which owns the code, phase and status outputs.
`timescale 1ns/1ps
interface sar_adc_sequencer_if;
    logic       Start;
    logic       TrackEn;
    logic       Comp;
    logic       Ready;
    logic [7:0] SAROut;
    logic [1:0] StateP;
    logic       SampleEn;
    logic       Inc;
    logic       Dcr;
    logic       Busy;
    logic       Done;
    logic [7:0] Result;

    modport master (
        output Start, TrackEn, Comp, Ready,
        input  SAROut, StateP, SampleEn, Inc, Dcr, Busy, Done, Result
    );

    modport slave (
        input  Start, TrackEn, Comp, Ready,
        output SAROut, StateP, SampleEn, Inc, Dcr, Busy, Done, Result
    );
endinterface

// File: rtl/sar_adc_sequencer.sv
// Successive-approximation sequencer: sample, 8-bit binary search, then
// optional +/-1 LSB tracking driven by timer Ready ticks.
`timescale 1ns/1ps
module sar_adc_sequencer #(
    parameter int SAMPLE_CYCLES = 2,   // 1..15
    parameter int SETTLE        = 1    // 0..7, slot length is SETTLE+1
) (
    input logic              ClockT,
    input logic              ResetN,
    sar_adc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        TRACK   = 2'd3
    } state_t;

    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_UP   = 2'b01;
    localparam logic [1:0] PH_DOWN = 2'b10;
    localparam logic [1:0] PH_CONV = 2'b11;

    state_t     state_reg;
    logic [3:0] cnt_reg;       // sample-cycle count, then settle-cycle count
    logic [2:0] bit_reg;       // bit currently under trial
    logic       ready_reg;     // Ready captured in TRACK, acted on next edge
    logic       comp_reg;      // Comp captured alongside Ready

    logic [7:0] sar_reg;
    logic [7:0] result_reg;
    logic [1:0] statep_reg;
    logic       sample_en_reg;
    logic       inc_reg;
    logic       dcr_reg;
    logic       busy_reg;
    logic       done_reg;

    // Code after deciding the current bit: keep or clear bit i from the
    // comparator, and raise bit i-1 as the next trial in the same update.
    logic [7:0] decided;
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_decide
            assign decided[gi] = (bit_reg == 3'(gi))              ? (sar_reg[gi] & bus.Comp) :
                                 ({1'b0, bit_reg} == 4'(gi + 1))  ? 1'b1 :
                                                                    sar_reg[gi];
        end
    endgenerate

    // Tracking steps saturate at the ends of the code range.
    logic can_up;
    logic can_down;
    assign can_up   = comp_reg  && (sar_reg != 8'hFF);
    assign can_down = !comp_reg && (sar_reg != 8'h00);

    // Single state machine with all outputs registered.
    always_ff @(posedge ClockT or negedge ResetN) begin
        if (!ResetN) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            bit_reg       <= 3'd0;
            ready_reg     <= 1'b0;
            comp_reg      <= 1'b0;
            sar_reg       <= 8'h00;
            result_reg    <= 8'h00;
            statep_reg    <= PH_IDLE;
            sample_en_reg <= 1'b0;
            inc_reg       <= 1'b0;
            dcr_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            inc_reg   <= 1'b0;
            dcr_reg   <= 1'b0;
            done_reg  <= 1'b0;
            ready_reg <= bus.Ready && (state_reg == TRACK);
            comp_reg  <= bus.Comp;

            case (state_reg)
                IDLE: begin
                    statep_reg <= PH_IDLE;
                    if (bus.Start) begin
                        state_reg <= SAMPLE;
                        cnt_reg   <= 4'd0;
                    end
                end

                // First cycle here is the capture cycle; the switch then
                // stays closed for SAMPLE_CYCLES cycles.
                SAMPLE: begin
                    if (cnt_reg == 4'(SAMPLE_CYCLES)) begin
                        state_reg     <= CONVERT;
                        cnt_reg       <= 4'd0;
                        bit_reg       <= 3'd7;
                        sar_reg       <= 8'h80;
                        sample_en_reg <= 1'b0;
                        statep_reg    <= PH_CONV;
                        busy_reg      <= 1'b1;
                    end else begin
                        cnt_reg       <= cnt_reg + 4'd1;
                        sample_en_reg <= 1'b1;
                        statep_reg    <= PH_IDLE;
                        busy_reg      <= 1'b1;
                    end
                end

                // Comparator is used only in the last cycle of each slot so
                // the DAC has SETTLE extra cycles to settle first.
                CONVERT: begin
                    if (cnt_reg == 4'(SETTLE)) begin
                        cnt_reg <= 4'd0;
                        sar_reg <= decided;
                        if (bit_reg == 3'd0) begin
                            result_reg <= decided;
                            done_reg   <= 1'b1;
                            busy_reg   <= 1'b0;
                            statep_reg <= PH_IDLE;
                            state_reg  <= bus.TrackEn ? TRACK : IDLE;
                        end else begin
                            bit_reg <= bit_reg - 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end

                // Start beats TrackEn, which beats a pending Ready step.
                TRACK: begin
                    if (bus.Start) begin
                        state_reg <= SAMPLE;
                        cnt_reg   <= 4'd0;
                    end else if (!bus.TrackEn) begin
                        state_reg  <= IDLE;
                        statep_reg <= PH_IDLE;
                    end else if (ready_reg) begin
                        if (can_up) begin
                            sar_reg    <= sar_reg + 8'd1;
                            result_reg <= sar_reg + 8'd1;
                            inc_reg    <= 1'b1;
                            statep_reg <= PH_UP;
                        end else if (can_down) begin
                            sar_reg    <= sar_reg - 8'd1;
                            result_reg <= sar_reg - 8'd1;
                            dcr_reg    <= 1'b1;
                            statep_reg <= PH_DOWN;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.SAROut   = sar_reg;
    assign bus.StateP   = statep_reg;
    assign bus.SampleEn = sample_en_reg;
    assign bus.Inc      = inc_reg;
    assign bus.Dcr      = dcr_reg;
    assign bus.Busy     = busy_reg;
    assign bus.Done     = done_reg;
    assign bus.Result   = result_reg;
endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Bench for sar_adc_sequencer: default and fast parameter sets side by side,
// an ideal comparator, and a behavioural model of search and tracking.
`timescale 1ns/1ps
module tb_sar_adc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] vin = 8'h00;
    logic       ovr_en = 1'b0;
    logic       ovr_val = 1'b0;
    logic       start_drv = 1'b0;
    logic       track_drv = 1'b0;
    logic       ready_drv = 1'b0;
    logic       sel = 1'b0;

    sar_adc_sequencer_if ia ();
    sar_adc_sequencer_if ib ();

    assign ia.Start   = start_drv;
    assign ia.TrackEn = track_drv;
    assign ia.Ready   = ready_drv;
    assign ia.Comp    = ovr_en ? ovr_val : (vin >= ia.SAROut);
    assign ib.Start   = start_drv;
    assign ib.TrackEn = track_drv;
    assign ib.Ready   = ready_drv;
    assign ib.Comp    = ovr_en ? ovr_val : (vin >= ib.SAROut);

    sar_adc_sequencer dut_a (.ClockT(clk), .ResetN(rst_n), .bus(ia));
    sar_adc_sequencer #(.SAMPLE_CYCLES(1), .SETTLE(0)) dut_b (.ClockT(clk), .ResetN(rst_n), .bus(ib));

    wire [7:0] o_sar    = sel ? ib.SAROut   : ia.SAROut;
    wire [7:0] o_result = sel ? ib.Result   : ia.Result;
    wire [1:0] o_statep = sel ? ib.StateP   : ia.StateP;
    wire       o_sample = sel ? ib.SampleEn : ia.SampleEn;
    wire       o_inc    = sel ? ib.Inc      : ia.Inc;
    wire       o_dcr    = sel ? ib.Dcr      : ia.Dcr;
    wire       o_busy   = sel ? ib.Busy     : ia.Busy;
    wire       o_done   = sel ? ib.Done     : ia.Done;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state: last published result, tracked code, last step direction.
    logic [7:0] exp_res  = 8'h00;
    logic [7:0] exp_code = 8'h00;
    logic [1:0] exp_sp   = 2'b00;
    logic       sp_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ideal binary search: all decided bits equal the input's bits, the
    // trial bit is the next one down.
    function automatic logic [7:0] trial_code(input logic [7:0] v, input int j);
        logic [7:0] keep_mask;
        logic [7:0] trial_bit;
        keep_mask = 8'hFF >> j;
        trial_bit = 8'h80 >> j;
        return (v & ~keep_mask) | trial_bit;
    endfunction

    task automatic check_reset_outputs(input string who);
        chk({who, "_rst_sar"},    o_sar, 8'h00);
        chk({who, "_rst_result"}, o_result, 8'h00);
        chk({who, "_rst_statep"}, o_statep, 2'b00);
        chk({who, "_rst_sample"}, o_sample, 1'b0);
        chk({who, "_rst_incdcr"}, {o_inc, o_dcr}, 2'b00);
        chk({who, "_rst_busy"},   o_busy, 1'b0);
        chk({who, "_rst_done"},   o_done, 1'b0);
    endtask

    // One full conversion observed on DUT s (0: defaults, 1: fast set).
    task automatic convert(input logic s, input logic [7:0] v, input logic trk,
                           input logic poke, input logic with_ready);
        int sc;
        int st;
        int last;
        int busy_n;
        int j;
        sc     = s ? 1 : 2;
        st     = s ? 0 : 1;
        last   = 1 + sc + 8 * (st + 1);
        busy_n = 0;
        sel       = s;
        vin       = v;
        track_drv = trk;
        start_drv = 1'b1;
        ready_drv = with_ready;
        tick();                      // edge k
        start_drv = 1'b0;
        ready_drv = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e <= last) begin
                busy_n += int'(o_busy);
                chk("no_step_in_conv", {o_inc, o_dcr}, 2'b00);
                if (with_ready && e == 1)
                    chk("start_beats_ready_sar", o_sar, exp_code);
                if (e <= sc) begin
                    chk("sample_en", o_sample, 1'b1);
                    chk("statep_sample", o_statep, 2'b00);
                end else if (e < last) begin
                    j = (e - sc - 1) / (st + 1);
                    chk("trial_code", o_sar, trial_code(v, j));
                    chk("statep_conv", o_statep, 2'b11);
                end
                if (e < last) begin
                    chk("done_early", o_done, 1'b0);
                    chk("result_hold", o_result, exp_res);
                end else begin
                    chk("done", o_done, 1'b1);
                    chk("result", o_result, v);
                    chk("busy_cycles", busy_n, sc + 8 * (st + 1));
                    exp_res  = v;
                    exp_code = v;
                    sp_known = 1'b0;
                    $display("conv dut=%0d vin=%02h result=%02h busy=%0d", s, v, o_result, busy_n);
                end
            end else if (e == last + 1) begin
                chk("done_one_cycle", o_done, 1'b0);
            end
            start_drv = (poke && e == sc + 3) ? 1'b1 : 1'b0;
        end
        sel = 1'b0;
    endtask

    // Ready pulses on DUT A, one every 'gap' cycles (gap >= 3).
    task automatic track(input int n, input int gap);
        logic comp_m;
        logic exp_inc;
        logic exp_dcr;
        for (int p = 0; p < n; p++) begin
            comp_m    = ovr_en ? ovr_val : (vin >= exp_code);
            ready_drv = 1'b1;
            tick();                  // edge m
            ready_drv = 1'b0;
            tick();                  // edge m+1
            exp_inc = 1'b0;
            exp_dcr = 1'b0;
            if (comp_m && exp_code < 8'hFF) begin
                exp_code = exp_code + 8'd1;
                exp_inc  = 1'b1;
                exp_sp   = 2'b01;
                sp_known = 1'b1;
            end else if (!comp_m && exp_code > 8'h00) begin
                exp_code = exp_code - 8'd1;
                exp_dcr  = 1'b1;
                exp_sp   = 2'b10;
                sp_known = 1'b1;
            end
            exp_res = exp_code;
            chk("track_sar", o_sar, exp_code);
            chk("track_inc", o_inc, exp_inc);
            chk("track_dcr", o_dcr, exp_dcr);
            chk("track_result", o_result, exp_res);
            if (sp_known) chk("track_statep", o_statep, exp_sp);
            tick();
            chk("pulse_len", {o_inc, o_dcr}, 2'b00);
            $display("track step=%0d comp=%0b sar=%02h inc=%0b dcr=%0b", p, comp_m, o_sar, exp_inc, exp_dcr);
            repeat (gap - 3) tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        check_reset_outputs("a");
        sel = 1'b1; #1;
        check_reset_outputs("b");
        sel = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();

        // Directed 0xA5 conversion, then random inputs.
        convert(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (4) convert(1'b0, 8'($urandom_range(255)), 1'b0, 1'b0, 1'b0);

        // Start during conversion is ignored.
        convert(1'b0, 8'($urandom_range(255)), 1'b0, 1'b1, 1'b0);

        // Fast parameter set.
        convert(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (3) convert(1'b1, 8'($urandom_range(255)), 1'b0, 1'b0, 1'b0);

        // Tracking up from 0x10 to an input of 0x13, then dither.
        convert(1'b0, 8'h10, 1'b1, 1'b0, 1'b0);
        vin = 8'h13;
        track(8, 4);

        // Start together with Ready while tracking.
        convert(1'b0, 8'h77, 1'b1, 1'b0, 1'b1);

        // Saturation at both ends.
        convert(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        track(3, 4);
        convert(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        ovr_en  = 1'b1;
        ovr_val = 1'b0;
        track(3, 4);
        ovr_en  = 1'b0;

        // Random tracking with an input offset from the converted code.
        convert(1'b0, 8'($urandom_range(20, 235)), 1'b1, 1'b0, 1'b0);
        vin = 8'(int'(vin) + $urandom_range(0, 8) - 4);
        track(6, 3);
        track_drv = 1'b0;
        repeat (3) tick();

        // Reset while bit 4 of a conversion is under trial.
        vin       = 8'($urandom_range(255));
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("a_mid");
        sel = 1'b1; #1;
        check_reset_outputs("b_mid");
        sel = 1'b0;
        repeat (2) tick();
        @(negedge clk) rst_n = 1'b1;
        exp_res  = 8'h00;
        exp_code = 8'h00;
        for (int e = 0; e < 25; e++) begin
            tick();
            chk("no_resume_done", o_done, 1'b0);
            chk("no_resume_busy", o_busy, 1'b0);
        end
        chk("no_resume_sar", o_sar, 8'h00);
        $display("reset mid-conversion released, idle");

        convert(1'b0, 8'($urandom_range(255)), 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
